// File: rtl/tsqr_rd_pkg.sv
// Shared types and constants for the TSQR result-memory drain engine.
// Optional tile header beat is enabled with the TSQR_RD_TILE_HDR_EN macro.
package tsqr_rd_pkg;

   localparam int LINE_W_DEF     = 16384;
   localparam int BEAT_W_DEF     = 512;
   localparam int BEATS_PER_LINE = LINE_W_DEF / BEAT_W_DEF;
   localparam int BEAT_IDX_W     = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

   localparam int HDR_TILE_LSB   = 0;
   localparam int HDR_TILE_W     = 16;
   localparam int HDR_NLINES_LSB = 16;
   localparam int HDR_NLINES_W   = 9;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      STREAM,
      FIN
   } rd_state_t;

   function automatic int idx_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   function automatic logic [31:0] hdr_word(input logic [HDR_TILE_W-1:0]   tile,
                                            input logic [HDR_NLINES_W-1:0] nl);
      logic [31:0] w;
      w = '0;
      w[HDR_TILE_LSB +: HDR_TILE_W]     = tile;
      w[HDR_NLINES_LSB +: HDR_NLINES_W] = nl;
      return w;
   endfunction

endpackage

// File: rtl/tsqr_line_serializer.sv
// Holds one captured result line and emits it as LSB-first beats on a
// valid/ready stream; a single-beat load is used for the optional header.
module tsqr_line_serializer
   import tsqr_rd_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              load_single,
   input  logic [LINE_W-1:0] load_data,
   input  logic              last_line,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [BEAT_W-1:0] m_data,
   output logic              m_last,
   output logic              line_done
);

   localparam int BPL   = LINE_W / BEAT_W;
   localparam int IDX_W = idx_width(BPL);

   logic [LINE_W-1:0] line_p0;
   logic [IDX_W-1:0]  idx_p0;
   logic              single_p0;
   logic              vld_p0;
   logic              at_last;
   logic              hs;

   assign at_last   = single_p0 ? (idx_p0 == '0) : (idx_p0 == IDX_W'(BPL - 1));
   assign hs        = vld_p0 && m_ready;
   assign line_done = hs && at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0    <= 1'b0;
         idx_p0    <= '0;
         single_p0 <= 1'b0;
      end else if (load) begin
         vld_p0    <= 1'b1;
         idx_p0    <= '0;
         single_p0 <= load_single;
      end else if (hs) begin
         if (at_last) vld_p0 <= 1'b0;
         else         idx_p0 <= idx_p0 + IDX_W'(1);
      end
   end

   // Line buffer is pure data; outputs are gated by valid so it needs no reset.
   always_ff @(posedge clk) begin
      if (load) line_p0 <= load_data;
   end

   assign m_valid = vld_p0;
   assign m_data  = vld_p0 ? line_p0[int'(idx_p0) * BEAT_W +: BEAT_W] : '0;
   assign m_last  = vld_p0 && at_last && last_line;

endmodule

// File: rtl/tsqr_dma_reader.sv
// Drains n_lines result lines from one TSQR result bank and streams them out
// as beats. Define TSQR_RD_TILE_HDR_EN to prepend a tile header beat.
module tsqr_dma_reader
   import tsqr_rd_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int ADDR_W = 8,
   parameter int NBANK  = 3,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NBANK-1:0]  bank_sel,
   input  logic [ADDR_W:0]   n_lines,
   input  logic [15:0]       tile_no,
   output logic [NBANK-1:0]  dma_mem_enb,
   output logic [ADDR_W-1:0] dma_mem_addrb,
   input  logic [LINE_W-1:0] dma_mem_doutb,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [BEAT_W-1:0] m_data,
   output logic              m_last,
   output logic [15:0]       m_tile,
   output logic              busy,
   output logic              done
);

   if (LINE_W % BEAT_W != 0) begin : g_bad_beat_w
      $error("LINE_W must be a multiple of BEAT_W");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("RD_LAT must be in 1..4");
   end

   rd_state_t         state;
   logic [NBANK-1:0]  bank_q;
   logic [ADDR_W:0]   nl_q;
   logic [ADDR_W:0]   cnt_q;
   logic [ADDR_W:0]   cnt_inc;
   logic [2:0]        wait_cnt;
   logic [NBANK-1:0]  sel_low;
   logic              degen;
   logic              wait_last;
   logic              ser_load;
   logic              ser_single;
   logic [LINE_W-1:0] ser_data;
   logic              last_line;
   logic              line_done;

   // Multi-hot selects collapse to their lowest set bit.
   assign sel_low   = bank_sel & (~bank_sel + NBANK'(1));
   assign degen     = (n_lines == '0) || (bank_sel == '0);
   assign cnt_inc   = cnt_q + (ADDR_W + 1)'(1);
   assign wait_last = (state == WAIT) && (wait_cnt == 3'(RD_LAT - 1));

`ifdef TSQR_RD_TILE_HDR_EN
   logic hdr_pend;
   logic degen_q;

   assign ser_load   = wait_last || ((state == IDLE) && start);
   assign ser_single = (state == IDLE);
   assign ser_data   = (state == IDLE) ?
                       LINE_W'(hdr_word(tile_no, HDR_NLINES_W'(n_lines))) : dma_mem_doutb;
   assign last_line  = hdr_pend ? degen_q : (cnt_inc >= nl_q);
`else
   assign ser_load   = wait_last;
   assign ser_single = 1'b0;
   assign ser_data   = dma_mem_doutb;
   assign last_line  = (cnt_inc >= nl_q);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         bank_q        <= '0;
         nl_q          <= '0;
         cnt_q         <= '0;
         wait_cnt      <= '0;
         dma_mem_enb   <= '0;
         dma_mem_addrb <= '0;
         m_tile        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef TSQR_RD_TILE_HDR_EN
         hdr_pend      <= 1'b0;
         degen_q       <= 1'b0;
`endif
      end else begin
         done        <= 1'b0;
         dma_mem_enb <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  bank_q <= sel_low;
                  nl_q   <= n_lines;
                  m_tile <= tile_no;
                  cnt_q  <= '0;
                  busy   <= 1'b1;
`ifdef TSQR_RD_TILE_HDR_EN
                  hdr_pend <= 1'b1;
                  degen_q  <= degen;
                  state    <= STREAM;
`else
                  if (degen) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state         <= ISSUE;
                     dma_mem_enb   <= sel_low;
                     dma_mem_addrb <= '0;
                  end
`endif
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_last) state <= STREAM;
               else           wait_cnt <= wait_cnt + 3'd1;
            end
            STREAM: begin
               if (line_done) begin
`ifdef TSQR_RD_TILE_HDR_EN
                  if (hdr_pend) begin
                     hdr_pend <= 1'b0;
                     if (degen_q) begin
                        state <= FIN;
                        done  <= 1'b1;
                     end else begin
                        state         <= ISSUE;
                        dma_mem_enb   <= bank_q;
                        dma_mem_addrb <= '0;
                     end
                  end else
`endif
                  if (cnt_inc < nl_q) begin
                     cnt_q         <= cnt_inc;
                     dma_mem_addrb <= cnt_inc[ADDR_W-1:0];
                     dma_mem_enb   <= bank_q;
                     state         <= ISSUE;
                  end else begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line capture / beat serialization stage
   tsqr_line_serializer #(
      .LINE_W (LINE_W),
      .BEAT_W (BEAT_W)
   ) u_ser (
      .clk         (clk),
      .rst_n       (rst),
      .load        (ser_load),
      .load_single (ser_single),
      .load_data   (ser_data),
      .last_line   (last_line),
      .m_ready     (m_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_last      (m_last),
      .line_done   (line_done)
   );

endmodule

// File: tb/tsqr_dma_reader_tb_note.sv
// Intentionally empty companion file (kept out of the build).

// File: tb/tb_tsqr_dma_reader.sv
// Scoreboard bench for tsqr_dma_reader with a behavioural result-memory model.
module tb_tsqr_dma_reader;

   localparam int LINE_W = 16384;
   localparam int BEAT_W = 512;
   localparam int ADDR_W = 8;
   localparam int NBANK  = 3;
   localparam int RD_LAT = 2;
   localparam int BPL    = LINE_W / BEAT_W;
   localparam int RW     = NBANK + ADDR_W;

   typedef struct {
      logic [BEAT_W-1:0] data;
      logic              last;
      logic [15:0]       tile;
   } beat_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic [NBANK-1:0]  bank_sel;
   logic [ADDR_W:0]   n_lines;
   logic [15:0]       tile_no;
   logic [NBANK-1:0]  dma_mem_enb;
   logic [ADDR_W-1:0] dma_mem_addrb;
   logic [LINE_W-1:0] dma_mem_doutb;
   logic              m_valid;
   logic              m_ready;
   logic [BEAT_W-1:0] m_data;
   logic              m_last;
   logic [15:0]       m_tile;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   int ready_mode = 0;
   int done_cnt = 0;
   logic [31:0] salt = 32'h0;

   beat_t           exp_q[$];
   logic [RW-1:0]   rd_q[$];
   logic [LINE_W-1:0] pipe [RD_LAT];

   tsqr_dma_reader #(
      .LINE_W (LINE_W),
      .BEAT_W (BEAT_W),
      .ADDR_W (ADDR_W),
      .NBANK  (NBANK),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .bank_sel      (bank_sel),
      .n_lines       (n_lines),
      .tile_no       (tile_no),
      .dma_mem_enb   (dma_mem_enb),
      .dma_mem_addrb (dma_mem_addrb),
      .dma_mem_doutb (dma_mem_doutb),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_last        (m_last),
      .m_tile        (m_tile),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [BEAT_W-1:0] act,
                               input logic [BEAT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Content of beat b of line addr in bank bk (low word = addr*32+b).
   function automatic logic [BEAT_W-1:0] beat_val(input int bk, input int addr, input int b,
                                                  input logic [31:0] s);
      logic [BEAT_W-1:0] v;
      v = {(BEAT_W/32){s ^ 32'(bk * 32'h0101_0000)}};
      v[31:0] = 32'(addr * BPL + b);
      return v;
   endfunction

   // Result memory: RD_LAT-deep read pipeline; idle cycles return noise.
   always @(posedge clk) begin : mem_model
      logic [LINE_W-1:0] nl;
      int bk;
      bk = -1;
      for (int i = 0; i < NBANK; i++) if (dma_mem_enb[i]) bk = i;
      if (bk >= 0) begin
         for (int b = 0; b < BPL; b++)
            nl[b*BEAT_W +: BEAT_W] = beat_val(bk, int'(dma_mem_addrb), b, salt);
      end else begin
         nl = {(LINE_W/32){$urandom()}};
      end
      pipe[0] <= nl;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign dma_mem_doutb = pipe[RD_LAT-1];

   initial m_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: compares every beat handshake and every read enable.
   always @(negedge clk) begin : monitor
      logic              prev_stall;
      logic [BEAT_W-1:0] prev_data;
      logic              prev_last;
      beat_t             e;
      logic [RW-1:0]     r;
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", BEAT_W'(m_valid), BEAT_W'(1));
            chk("hold_data", m_data, prev_data);
            chk("hold_last", BEAT_W'(m_last), BEAT_W'(prev_last));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", BEAT_W'(m_valid), BEAT_W'(0));
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_data, e.data);
               chk("beat_last", BEAT_W'(m_last), BEAT_W'(e.last));
               chk("beat_tile", BEAT_W'(m_tile), BEAT_W'(e.tile));
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (dma_mem_enb != '0) begin
            chk("enb_onehot", BEAT_W'($onehot(dma_mem_enb)), BEAT_W'(1));
            if (rd_q.size() == 0) begin
               chk("unexpected_read", BEAT_W'({dma_mem_enb, dma_mem_addrb}), BEAT_W'(0));
            end else begin
               r = rd_q.pop_front();
               chk("read_addr", BEAT_W'({dma_mem_enb, dma_mem_addrb}), BEAT_W'(r));
            end
         end
         if (done) done_cnt++;
      end
   end

   // Reference model: expected reads and beats for one request.
   task automatic expect_req(input logic [NBANK-1:0] sel, input int n, input logic [15:0] tile);
      int    bk;
      bit    deg;
      beat_t e;
      deg = (n == 0) || (sel == '0);
      bk = -1;
      for (int i = NBANK - 1; i >= 0; i--) if (sel[i]) bk = i;
`ifdef TSQR_RD_TILE_HDR_EN
      e.data = '0;
      e.data[15:0]  = tile;
      e.data[24:16] = 9'(n);
      e.last = deg;
      e.tile = tile;
      exp_q.push_back(e);
`endif
      if (!deg) begin
         for (int k = 0; k < n; k++) begin
            rd_q.push_back({NBANK'(1 << bk), ADDR_W'(k)});
            for (int b = 0; b < BPL; b++) begin
               e.data = beat_val(bk, k, b, salt);
               e.last = (k == n - 1) && (b == BPL - 1);
               e.tile = tile;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic run_req(input logic [NBANK-1:0] sel, input int n, input logic [15:0] tile,
                          input int mode, input int inj);
      int first_v;
      int done_t;
      int bound;
      bit deg;
      ready_mode = mode;
      deg = (n == 0) || (sel == '0);
      expect_req(sel, n, tile);
      @(posedge clk); #1;
      start = 1'b1; bank_sel = sel; n_lines = (ADDR_W + 1)'(n); tile_no = tile;
      @(posedge clk); #1;
      start = 1'b0; bank_sel = NBANK'($urandom); n_lines = (ADDR_W + 1)'($urandom);
      tile_no = 16'($urandom);
      first_v = -1;
      done_t  = -1;
      bound   = n * BPL * 4 + 200;
      for (int t = 1; t <= bound && done_t < 0; t++) begin
         @(negedge clk);
         if (t == inj) begin
            start = 1'b1; bank_sel = 3'b001; n_lines = 9'd3; tile_no = 16'h00AB;
         end else if (t == inj + 1) begin
            start = 1'b0;
         end
         if (m_valid && first_v < 0) first_v = t;
         if (done) begin
            done_t = t;
            chk("busy_at_done", BEAT_W'(busy), BEAT_W'(1));
         end
      end
      chk("done_seen", BEAT_W'(done_t >= 0), BEAT_W'(1));
`ifdef TSQR_RD_TILE_HDR_EN
      chk("first_valid_cycle", BEAT_W'(first_v), BEAT_W'(1));
`else
      if (deg) begin
         chk("degen_done_cycle", BEAT_W'(done_t), BEAT_W'(1));
         chk("degen_no_valid", BEAT_W'(first_v), BEAT_W'(-1));
      end else begin
         chk("first_valid_cycle", BEAT_W'(first_v), BEAT_W'(2 + RD_LAT));
      end
`endif
      @(negedge clk);
      chk("busy_after_done", BEAT_W'(busy), BEAT_W'(0));
      chk("done_one_cycle", BEAT_W'(done), BEAT_W'(0));
      chk("beats_all_seen", BEAT_W'(exp_q.size()), BEAT_W'(0));
      chk("reads_all_seen", BEAT_W'(rd_q.size()), BEAT_W'(0));
      chk("m_tile_latched", BEAT_W'(m_tile), BEAT_W'(tile));
   endtask

   task automatic check_zero();
      chk("rst_enb", BEAT_W'(dma_mem_enb), BEAT_W'(0));
      chk("rst_addrb", BEAT_W'(dma_mem_addrb), BEAT_W'(0));
      chk("rst_m_valid", BEAT_W'(m_valid), BEAT_W'(0));
      chk("rst_m_data", m_data, BEAT_W'(0));
      chk("rst_m_last", BEAT_W'(m_last), BEAT_W'(0));
      chk("rst_m_tile", BEAT_W'(m_tile), BEAT_W'(0));
      chk("rst_busy", BEAT_W'(busy), BEAT_W'(0));
      chk("rst_done", BEAT_W'(done), BEAT_W'(0));
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit found;
      int dcnt;
      rst = 1'b0; start = 1'b0; bank_sel = '0; n_lines = '0; tile_no = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero();
      rst = 1'b1;

      salt = 32'h0;
      run_req(3'b010, 2, 16'h0001, 0, -1);

      salt = 32'hA5A5_0001;
      run_req(3'b001, 2, 16'h0102, 1, -1);

      for (int r = 0; r < 4; r++) begin
         salt = $urandom;
         run_req(NBANK'($urandom_range(1, 7)), int'($urandom_range(1, 3)), 16'($urandom), 2, -1);
      end

      run_req(3'b100, 0, 16'h0D0D, 0, -1);
      run_req(3'b000, 4, 16'h0E0E, 0, -1);

      salt = 32'h1234_5678;
      run_req(3'b100, 3, 16'h5555, 0, 20);

      salt = 32'h0F0F_F0F0;
      run_req(3'b010, 256, 16'hBEEF, 0, -1);

      ready_mode = 0;
      salt = 32'h7777_0000;
      expect_req(3'b100, 6, 16'h7777);
      @(posedge clk); #1;
      start = 1'b1; bank_sel = 3'b100; n_lines = 9'd6; tile_no = 16'h7777;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 2000 && !found; t++) begin
         @(negedge clk);
         if (dma_mem_enb != '0 && dma_mem_addrb == 8'd3) found = 1'b1;
      end
      chk("reach_line3", BEAT_W'(found), BEAT_W'(1));
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check_zero();
      exp_q.delete();
      rd_q.delete();
      dcnt = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_done_on_reset", BEAT_W'(done_cnt), BEAT_W'(dcnt));
      salt = 32'h4242_0000;
      run_req(3'b001, 1, 16'h4242, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
